// File: rtl/mul_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) engine for the Y/bus_out -> Z path.
// Latency: start sampled at edge k -> done and z outputs valid in the cycle after edge k+34, data independent.
// Backpressure: none; start is taken only in IDLE, ignored otherwise (not queued); clear aborts at once.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] z_high,
   output logic [WIDTH-1:0] z_low
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int AW = 2 * WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   // Shared accumulator.
   // Multiply: {A[2W:W+1], Q[W:1], q-1[0]}.
   // Divide:   {R[2W:W], Q[W-1:0]}.
   // After FIX both ops leave {z_high, z_low, 1'b0} here.
   logic [AW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] m_q, m_d;      // multiplicand, or divisor magnitude
   logic [WIDTH-1:0] a_q, a_d;      // raw dividend, returned as remainder on divide-by-zero
   logic             op_q, op_d;
   logic             sa_q, sa_d;    // dividend sign
   logic             sb_q, sb_d;    // divisor sign
   logic             bz_q, bz_d;    // divisor was zero
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] zh_q, zh_d;
   logic [WIDTH-1:0] zl_q, zl_d;

   // Next-state, datapath iteration and output-register loads.
   always_comb begin
      logic [WIDTH:0]   a_ext;
      logic [WIDTH:0]   m_ext;
      logic [WIDTH:0]   booth_sum;
      logic [WIDTH:0]   r_sh;
      logic [WIDTH:0]   trial;
      logic [WIDTH-1:0] q_mag;
      logic [WIDTH-1:0] r_mag;
      logic [WIDTH-1:0] q_fix;
      logic [WIDTH-1:0] r_fix;

      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      m_d       = m_q;
      a_d       = a_q;
      op_d      = op_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      bz_d      = bz_q;
      done_d    = 1'b0;
      dbz_d     = dbz_q;
      zh_d      = zh_q;
      zl_d      = zl_q;

      // Booth step: sign-extend A and M to WIDTH+1 so the add or subtract can never
      // overflow (matters when M is the most negative value), then shift.
      a_ext     = {acc_q[AW-1], acc_q[AW-1:WIDTH+1]};
      m_ext     = {m_q[WIDTH-1], m_q};
      booth_sum = a_ext;
      case (acc_q[1:0])
         2'b01:   booth_sum = a_ext + m_ext;
         2'b10:   booth_sum = a_ext - m_ext;
         default: booth_sum = a_ext;
      endcase

      // Restoring step: shift remainder left, pull in the next dividend bit and trial-subtract.
      r_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      trial = r_sh - {1'b0, m_q};

      // Sign correction on the magnitude results.
      q_mag = acc_q[WIDTH-1:0];
      r_mag = acc_q[2*WIDTH-1:WIDTH];
      q_fix = (sa_q ^ sb_q) ? -q_mag : q_mag;
      r_fix = sa_q ? -r_mag : r_mag;
      if (bz_q) begin
         q_fix = '1;
         r_fix = a_q;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d  = op;
               a_d   = operand_a;
               sa_d  = operand_a[WIDTH-1];
               sb_d  = operand_b[WIDTH-1];
               bz_d  = (operand_b == '0);
               cnt_d = CW'(WIDTH);
               if (!op) begin
                  m_d   = operand_b;
                  acc_d = {{WIDTH{1'b0}}, operand_a, 1'b0};
               end else begin
                  // Negating 0x80000000 yields the same bits, read as unsigned 2^31.
                  m_d   = operand_b[WIDTH-1] ? -operand_b : operand_b;
                  acc_d = {{(WIDTH+1){1'b0}},
                           (operand_a[WIDTH-1] ? -operand_a : operand_a)};
               end
               state_d = RUN;
            end
         end
         RUN: begin
            if (!op_q) begin
               acc_d = {booth_sum, acc_q[WIDTH:1]};
            end else if (trial[WIDTH]) begin
               acc_d = {r_sh, acc_q[WIDTH-2:0], 1'b0};
            end else begin
               acc_d = {trial, acc_q[WIDTH-2:0], 1'b1};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (op_q) begin
               acc_d = {r_fix, q_fix, 1'b0};
            end
            state_d = DONE;
         end
         DONE: begin
            zh_d    = acc_q[AW-1:WIDTH+1];
            zl_d    = acc_q[WIDTH:1];
            dbz_d   = op_q & bz_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN) || (state_d == FIX);
   end

   // State and output registers; clear overrides everything, including start.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         m_q     <= '0;
         a_q     <= '0;
         op_q    <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         bz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         zh_q    <= '0;
         zl_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         a_q     <= a_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         bz_q    <= bz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         zh_q    <= zh_d;
         zl_q    <= zl_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign z_high      = zh_q;
   assign z_low       = zl_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed products/quotients, latency, handshake and clear.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Every result is compared against a constant worked out by hand.
module tb_mul_div_unit;

   logic        clock = 1'b0;
   logic        clear;
   logic        start;
   logic        op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] z_high;
   logic [31:0] z_low;

   int checks   = 0;
   int failures = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .z_high      (z_high),
      .z_low       (z_low)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pulse start for one edge (edge k); operands are scrambled right after so capture is tested.
   task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b, input string tag);
      @(negedge clock);
      op        = o;
      operand_a = a;
      operand_b = b;
      start     = 1'b1;
      @(posedge clock);
      #1;
      start     = 1'b0;
      op        = ~o;
      operand_a = 32'hA5A5_5A5A;
      operand_b = 32'hDEAD_BEEF;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
   endtask

   // Count edges after launch; report the edge index of the first done and the pulse count.
   task automatic watch(input int n, output int first, output int pulses);
      first  = 0;
      pulses = 0;
      for (int e = 1; e <= n; e++) begin
         @(posedge clock);
         #1;
         if (done === 1'b1) begin
            pulses++;
            if (first == 0) first = e;
         end
      end
   endtask

   task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed,
                         input string tag);
      int first;
      int pulses;
      launch(o, a, b, tag);
      watch(34, first, pulses);
      chk({tag, "_lat"}, first, 32'd34);
      chk({tag, "_hi"}, z_high, eh);
      chk({tag, "_lo"}, z_low, el);
      chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ed});
      watch(6, first, pulses);
      chk({tag, "_pulses"}, pulses, 32'd0);
      chk({tag, "_hold_lo"}, z_low, el);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first;
      int pulses;

      clear     = 1'b1;
      start     = 1'b0;
      op        = 1'b0;
      operand_a = '0;
      operand_b = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
      chk("rst_hi",   z_high, 32'd0);
      chk("rst_lo",   z_low, 32'd0);
      @(negedge clock);
      clear = 1'b0;

      // Multiply: 7 * -3 = -21
      run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mul_7x-3");
      // (-2^31)^2 = 2^62
      run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mul_min2");
      // -1 * -1 = 1
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, "mul_m1m1");
      // -7 / 2 = -3 rem -1
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_-7_2");
      // 7 / -2 = -3 rem 1
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_7_-2");
      // -2^31 / -1 wraps to 0x80000000 rem 0
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_min_m1");
      // divide by zero
      run_op(1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, "div_zero");

      // Handshake: 0x12345678 * 9 = 0xA3D70A38; start re-pulsed and operand_b changed mid-run.
      launch(1'b0, 32'h1234_5678, 32'd9, "hs");
      first  = 0;
      pulses = 0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clock);
         #1;
         if (done === 1'b1) begin
            pulses++;
            if (first == 0) first = e;
         end
         start = (e == 5 || e == 20);
         if (e == 5 || e == 20) begin
            operand_b = 32'h0000_0055;
            operand_a = 32'h0000_0003;
            op        = 1'b1;
         end
      end
      chk("hs_lat",    first, 32'd34);
      chk("hs_pulses", pulses, 32'd1);
      chk("hs_hi",     z_high, 32'h0000_0000);
      chk("hs_lo",     z_low, 32'hA3D7_0A38);
      chk("hs_dbz",    {31'd0, div_by_zero}, 32'd0);

      // Outputs hold while a second operation (100 / 7 = 14 rem 2) runs.
      launch(1'b1, 32'd100, 32'd7, "hold");
      first  = 0;
      for (int e = 1; e <= 34; e++) begin
         @(posedge clock);
         #1;
         if (done === 1'b1 && first == 0) first = e;
         if (e == 10 || e == 33) begin
            chk("hold_mid_lo", z_low, 32'hA3D7_0A38);
            chk("hold_mid_hi", z_high, 32'h0000_0000);
         end
      end
      chk("hold_lat", first, 32'd34);
      chk("hold_lo",  z_low, 32'd14);
      chk("hold_hi",  z_high, 32'd2);

      // clear at cycle 10 of a multiply
      launch(1'b0, 32'd5, 32'd6, "clr");
      repeat (8) @(posedge clock);
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock);
      #1;
      chk("clr_busy", {31'd0, busy}, 32'd0);
      chk("clr_done", {31'd0, done}, 32'd0);
      chk("clr_hi",   z_high, 32'd0);
      chk("clr_lo",   z_low, 32'd0);
      @(negedge clock);
      clear = 1'b0;
      watch(40, first, pulses);
      chk("clr_nodone", pulses, 32'd0);

      // clear together with start from IDLE: nothing starts
      @(negedge clock);
      clear     = 1'b1;
      start     = 1'b1;
      op        = 1'b0;
      operand_a = 32'd3;
      operand_b = 32'd4;
      @(posedge clock);
      #1;
      clear = 1'b0;
      start = 1'b0;
      chk("clrst_busy", {31'd0, busy}, 32'd0);
      watch(40, first, pulses);
      chk("clrst_nodone", pulses, 32'd0);
      chk("clrst_lo", z_low, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
